fetch_decode_stage: RTL
=======================

Name: fetch_decode_stage

Overview:
- First stage of the two-stage processor; sits directly upstream of the execute stage.
- Fetches 32-bit instructions from a synchronous instruction memory and decodes them.
- Reads a 32x32 register file and drives the execute stage's enable_ex, src1, src2, imm and control_in inputs.
- Owns the PC and accepts register write-back and branch redirects from the execute stage.

Parameters:
IMEM_AW, 10, instruction memory word-address width; imem_addr = pc[IMEM_AW+1:2]
RESET_PC, 32'h0000_0000, PC value loaded on reset
HALT_OP, 7'h7F, opcode that stops fetching

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
enable_fd  input  1  run enable; sampled in IDLE and at the end of ISSUE
imem_en  output  1  instruction memory read strobe
imem_addr  output  IMEM_AW  instruction memory word address
imem_rdata  input  32  instruction word; valid the cycle after imem_en
wb_en  input  1  register write enable from execute
wb_addr  input  5  write-back register index
wb_data  input  32  write-back data (execute aluout)
branch_taken  input  1  redirect request from execute
branch_target  input  32  new PC, byte address, bits [1:0] ignored
enable_ex  output  1  one-cycle issue pulse to execute
src1  output  32  rs1 operand
src2  output  32  rs2 operand
imm  output  32  sign-extended immediate
control_in  output  7  opcode passed to execute
pc_out  output  32  PC of the issued instruction
halted  output  1  high in HALT

Behaviour:
- Instruction format: opcode [31:25] -> control_in; rd [24:20] is unused here; rs1 [19:15]; rs2 [14:10]; imm = sign-extend of [14:0].
- The imm field overlaps the rs2 field; execute chooses which one to use.
- Reset (synchronous, highest priority):
  - pc = RESET_PC; state = IDLE.
  - enable_ex, imem_en, halted, src1, src2, imm, control_in and pc_out all go to 0.
  - All 32 registers clear to 0.
  - Reset asserted mid-operation abandons any fetch in flight.
- FSM states: IDLE, FETCH, ISSUE, HALT.
  - IDLE: imem_en = 0. Go to FETCH when enable_fd = 1.
  - FETCH: imem_en = 1, imem_addr = pc[IMEM_AW+1:2]. Always go to ISSUE.
  - ISSUE: imem_rdata is valid. On the ending edge, register all of the following:
    - control_in, imm, src1 = RF[rs1], src2 = RF[rs2], pc_out = pc;
    - enable_ex = 1 for exactly one cycle;
    - pc = pc + 4, wrapping modulo 2^32.
    - Next state: HALT if opcode == HALT_OP (the HALT instruction itself is still issued); else FETCH if enable_fd = 1; else IDLE.
  - HALT: halted = 1, imem_en = 0. Exit only through reset.
- Throughput: one instruction every 2 cycles.
- Fetch-to-issue latency: enable_ex rises 2 edges after FETCH is entered.
- enable_ex is 0 in every cycle that is not directly after an ISSUE edge.
- Register file:
  - 2 read ports, 1 write port.
  - Write on the clk edge when wb_en = 1 and wb_addr != 0.
  - r0 always reads 0.
  - Bypass: when wb_en = 1 and wb_addr equals a nonzero rs1/rs2 in the ISSUE cycle, the operand takes wb_data.
- Branch (priority below reset, above everything else):
  - branch_taken = 1 in IDLE, FETCH or ISSUE: pc = {branch_target[31:2], 2'b00}, state = FETCH, enable_ex = 0 next cycle.
  - An instruction in ISSUE is squashed and never issued.
  - A HALT opcode in ISSUE with branch_taken = 1 is squashed and does not halt.
  - branch_taken in HALT is ignored.
- enable_fd falling during FETCH: the pending instruction still issues, then the FSM goes to IDLE.
- Outputs other than enable_ex hold their last issued values until the next issue or reset.

Test Plan:
- Reset/start: reset = 1 for 2 cycles, then enable_fd = 1, imem[0] = {7'd5, 5'd0, 5'd0, 5'd0, 10'd0} -> imem_addr = 0 in FETCH; enable_ex pulses at cycle 2 with control_in = 5, src1 = src2 = 0, pc_out = 0; then imem_addr = 1.
- Write-back and read: wb_en = 1, wb_addr = 3, wb_data = 60; then issue rs1 = 3, rs2 = 4 with r4 = 89 -> src1 = 60, src2 = 89. A write with wb_addr = 0, wb_data = 99 leaves src = 0 for rs = 0.
- Bypass: wb_en = 1, wb_addr = 7, wb_data = 32'hDEAD_BEEF in the same ISSUE cycle that reads rs1 = 7 -> src1 = 32'hDEAD_BEEF.
- Immediate: instruction bits [14:0] = 15'h7FFC -> imm = 32'hFFFF_FFFC; bits [14:0] = 15'h0154 -> imm = 32'h0000_0154.
- Branch squash: branch_taken = 1, branch_target = 32'h0000_0043 in ISSUE -> no enable_ex next cycle; next FETCH imem_addr = 16; pc_out = 32'h40 on the next issue.
- Halt: opcode 7'h7F issued -> enable_ex pulses once with control_in = 7'h7F; halted = 1; imem_en stays 0 for 10 cycles; reset returns pc to 0 and halted to 0.

Source files
------------

// File: rtl/fetch_decode_stage.sv
// Fetch/decode stage: fetches from a synchronous instruction memory, decodes the word,
// reads the register file and issues one instruction every two cycles to execute.
module fetch_decode_stage #(
    parameter int unsigned IMEM_AW  = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [6:0]  HALT_OP  = 7'h7F
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_fd,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               wb_en,
    input  logic [4:0]         wb_addr,
    input  logic [31:0]        wb_data,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    output logic               enable_ex,
    output logic [31:0]        src1,
    output logic [31:0]        src2,
    output logic [31:0]        imm,
    output logic [6:0]         control_in,
    output logic [31:0]        pc_out,
    output logic               halted
);

    typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [32];

    logic        enable_ex_q;
    logic [31:0] src1_q, src2_q, imm_q, pc_out_q;
    logic [6:0]  ctrl_q;

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2;
    logic [31:0] imm_ext, rs1_val, rs2_val;
    logic        issue, redirect;
    logic        unused_bits;

    assign opcode  = imem_rdata[31:25];
    assign rs1     = imem_rdata[19:15];
    assign rs2     = imem_rdata[14:10];
    assign imm_ext = {{17{imem_rdata[14]}}, imem_rdata[14:0]};

    assign unused_bits = ^{imem_rdata[24:20], branch_target[1:0]};

    // Redirects are honoured everywhere except HALT, which only reset leaves.
    assign redirect = branch_taken && (state_q != StHalt);

    // Register file read with same-cycle write-back forwarding; r0 is hardwired to zero.
    always_comb begin
        rs1_val = rf_q[rs1];
        if (rs1 == 5'd0) begin
            rs1_val = '0;
        end else if (wb_en && (wb_addr == rs1)) begin
            rs1_val = wb_data;
        end
        rs2_val = rf_q[rs2];
        if (rs2 == 5'd0) begin
            rs2_val = '0;
        end else if (wb_en && (wb_addr == rs2)) begin
            rs2_val = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable_fd) state_d = StFetch;
            StFetch: state_d = StIssue;
            StIssue: begin
                if (opcode == HALT_OP) begin
                    state_d = StHalt;
                end else if (enable_fd) begin
                    state_d = StFetch;
                end else begin
                    state_d = StIdle;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
        if (redirect) begin
            state_d = StFetch;
        end
    end

    always_comb begin
        imem_en = (state_q == StFetch);
        halted  = (state_q == StHalt);
        issue   = (state_q == StIssue) && !branch_taken;
    end

    assign imem_addr = pc_q[IMEM_AW+1:2];

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = {branch_target[31:2], 2'b00};
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            enable_ex_q <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            imm_q       <= '0;
            ctrl_q      <= '0;
            pc_out_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            enable_ex_q <= issue;
            if (issue) begin
                src1_q   <= rs1_val;
                src2_q   <= rs2_val;
                imm_q    <= imm_ext;
                ctrl_q   <= opcode;
                pc_out_q <= pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    assign enable_ex  = enable_ex_q;
    assign src1       = src1_q;
    assign src2       = src2_q;
    assign imm        = imm_q;
    assign control_in = ctrl_q;
    assign pc_out     = pc_out_q;

endmodule
